// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage of the 5-stage RV32I pipeline.
//
// Owns the PC and assembles each 32-bit instruction from four byte reads over
// the shared 8-bit memory port (through the memory arbiter). The assembled
// {pc, inst} pair is presented with a valid flag and held while the pipeline
// stalls. A taken jump/branch from decode redirects on the next edge and
// discards any partially fetched instruction.
//
// Optional feature (compile-time macro ICACHE_EN): a direct-mapped I-cache of
// ICACHE_LINES one-word entries. A hit on a word-aligned PC delivers the
// instruction one cycle after entering FETCH without touching the byte port.
// Without the macro there is no cache storage and every fetch uses the port.
//
// Parameters:
//   RESET_PC      PC loaded at reset
//   ICACHE_LINES  number of I-cache entries (power of two, >= 2; ICACHE_EN only)
//
// Ports:
//   clk           clock, all state on the rising edge
//   rst           asynchronous active-low reset
//   stall_i       downstream cannot accept the instruction this cycle
//   jump_flag_i   redirect to jump_addr_i (highest priority)
//   jump_addr_i   redirect target byte address (used as-is)
//   mem_req_o     byte read request to the arbiter
//   mem_addr_o    byte address of the request
//   mem_grant_i   arbiter accepted the request this cycle
//   mem_data_i    read byte, valid the cycle after its grant
//   pc_o          PC of the presented instruction
//   inst_o        presented instruction
//   inst_valid_o  pc_o/inst_o valid
//   stallreq_o    fetch in progress, no instruction available
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        stallreq_o
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_VALID = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [2:0]  issue_q, issue_d;
  logic [2:0]  recv_q, recv_d;
  logic        inflight_q, inflight_d;
  logic        run_q;

  logic        cache_hit;
  logic [31:0] cache_word;
  logic        fetching;
  logic        grant_ok;

  // run_q keeps the port quiet until the first edge after reset release, so
  // the first request appears on that edge rather than during reset.
  assign fetching     = run_q && (state_q == S_FETCH) && !cache_hit;
  assign mem_req_o    = fetching && !issue_q[2];
  assign mem_addr_o   = mem_req_o ? (pc_q + {29'd0, issue_q}) : 32'd0;
  assign grant_ok     = mem_req_o && mem_grant_i;
  assign stallreq_o   = fetching;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = (state_q == S_VALID);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    issue_d    = issue_q;
    recv_d     = recv_q;
    inflight_d = 1'b0;

    if (jump_flag_i) begin
      // Clearing inflight drops the byte granted this cycle: it belongs to
      // the fetch being abandoned.
      pc_d    = jump_addr_i;
      state_d = S_FETCH;
      issue_d = 3'd0;
      recv_d  = 3'd0;
    end else if (state_q == S_VALID) begin
      if (!stall_i) begin
        pc_d    = pc_q + 32'd4;
        state_d = S_FETCH;
        issue_d = 3'd0;
        recv_d  = 3'd0;
      end
    end else if (cache_hit) begin
      inst_d  = cache_word;
      state_d = S_VALID;
    end else begin
      inflight_d = grant_ok;
      if (grant_ok) begin
        issue_d = issue_q + 3'd1;
      end
      if (inflight_q) begin
        // Little-endian assembly: byte k lands in inst[8k+7:8k].
        inst_d[{recv_q[1:0], 3'b000} +: 8] = mem_data_i;
        recv_d = recv_q + 3'd1;
        if (recv_q == 3'd3) begin
          state_d = S_VALID;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      inst_q     <= 32'd0;
      issue_q    <= 3'd0;
      recv_q     <= 3'd0;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      issue_q    <= issue_d;
      recv_q     <= recv_d;
      inflight_q <= inflight_d;
      run_q      <= 1'b1;
    end
  end

`ifdef ICACHE_EN
  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [ICACHE_LINES-1:0] cv_q;
  logic [31:0]             cdata_q [ICACHE_LINES];
  logic [TAG_W-1:0]        ctag_q  [ICACHE_LINES];
  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic                    aligned;
  logic                    fill;
  logic [31:0]             fill_word;

  assign idx       = pc_q[IDX_W+1:2];
  assign tag       = pc_q[31:IDX_W+2];
  assign aligned   = (pc_q[1:0] == 2'b00);
  assign cache_word = cdata_q[idx];

  // Lookup only before any byte has been issued; the cache cannot change
  // while a miss is in progress, so the result is stable for the fetch.
  assign cache_hit = run_q && (state_q == S_FETCH) && (issue_q == 3'd0) &&
                     (recv_q == 3'd0) && aligned && cv_q[idx] &&
                     (ctag_q[idx] == tag);

  // Fill when the last byte of an aligned miss arrives; a redirect in that
  // same cycle abandons the fetch and suppresses the fill.
  assign fill      = fetching && inflight_q && (recv_q == 3'd3) &&
                     !jump_flag_i && aligned;
  assign fill_word = {mem_data_i, inst_q[23:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cv_q <= '0;
    end else if (fill) begin
      cv_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      cdata_q[idx] <= fill_word;
      ctag_q[idx]  <= tag;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_word = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_grant_i;
  logic [7:0]  mem_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stallreq_o;

  int total = 0;
  int bad   = 0;

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_grant_i  (mem_grant_i),
    .mem_data_i   (mem_data_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  // Byte memory: a grant seen mid-cycle returns its byte during the next cycle.
  logic [7:0]  mem [0:511];
  logic        resp_pend = 1'b0;
  logic [31:0] resp_addr = 32'd0;

  always @(negedge clk) begin
    resp_pend = mem_req_o && mem_grant_i;
    resp_addr = mem_addr_o;
  end

  always @(posedge clk) begin
    #1;
    mem_data_i = resp_pend ? mem[resp_addr[8:0]] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Called in the first request cycle of a fetch (or later); bounded wait.
  task automatic wait_valid(input string tag, input int exp_n,
                            input logic [31:0] epc, input logic [31:0] einst);
    int n = 0;
    while (inst_valid_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd1);
    chk({tag, "_pc"}, pc_o, epc);
    chk({tag, "_inst"}, inst_o, einst);
    chk({tag, "_stallreq"}, {31'd0, stallreq_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    stall_i     = 1'b0;
    jump_flag_i = 1'b0;
    jump_addr_i = 32'd0;
    mem_grant_i = 1'b1;
    mem_data_i  = 8'h00;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h000] = 8'h13; mem[9'h001] = 8'h05; mem[9'h002] = 8'ha0; mem[9'h003] = 8'h00;
    mem[9'h004] = 8'h93; mem[9'h005] = 8'h05; mem[9'h006] = 8'h10; mem[9'h007] = 8'h00;
    mem[9'h008] = 8'hb3; mem[9'h009] = 8'h06; mem[9'h00a] = 8'hb5; mem[9'h00b] = 8'h00;
    mem[9'h00c] = 8'hef; mem[9'h00d] = 8'hbe; mem[9'h00e] = 8'had; mem[9'h00f] = 8'hde;
    mem[9'h020] = 8'hb7; mem[9'h021] = 8'hc0; mem[9'h022] = 8'hff; mem[9'h023] = 8'hee;
    mem[9'h040] = 8'h78; mem[9'h041] = 8'h56; mem[9'h042] = 8'h34; mem[9'h043] = 8'h12;
    mem[9'h100] = 8'h37; mem[9'h101] = 8'h12; mem[9'h102] = 8'h34; mem[9'h103] = 8'h00;
    mem[9'h1fe] = 8'h11; mem[9'h1ff] = 8'h22;

    // Reset state
    step();
    step();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);

    // First fetch at 0, grant always high
    rst = 1'b1;
    step();
    chk("f0_req", {31'd0, mem_req_o}, 32'd1);
    chk("f0_addr0", mem_addr_o, 32'h0);
    chk("f0_stallreq", {31'd0, stallreq_o}, 32'd1);
    step();
    chk("f0_addr1", mem_addr_o, 32'h1);
    step();
    chk("f0_addr2", mem_addr_o, 32'h2);
    step();
    chk("f0_addr3", mem_addr_o, 32'h3);
    wait_valid("f0", 2, 32'h0, 32'h00a00513);

    // Hold under stall for 3 cycles
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_valid", {31'd0, inst_valid_o}, 32'd1);
      chk("stall_pc", pc_o, 32'h0);
      chk("stall_inst", inst_o, 32'h00a00513);
      chk("stall_req", {31'd0, mem_req_o}, 32'd0);
    end
    stall_i = 1'b0;
    step();
    chk("cons_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("cons_pc", pc_o, 32'h4);
    chk("cons_addr", mem_addr_o, 32'h4);
    wait_valid("f4", 5, 32'h4, 32'h00100593);

    // Fetch at 8 with a 2-cycle grant gap
    step();
    chk("gap_pc", pc_o, 32'h8);
    chk("gap_addr_c1", mem_addr_o, 32'h8);
    mem_grant_i = 1'b0;
    step();
    chk("gap_addr_c2", mem_addr_o, 32'h8);
    chk("gap_req_c2", {31'd0, mem_req_o}, 32'd1);
    step();
    chk("gap_addr_c3", mem_addr_o, 32'h8);
    mem_grant_i = 1'b1;
    wait_valid("f8", 5, 32'h8, 32'h00b506b3);

    // Redirect to 0x100 after two bytes of the fetch at 0xC
    step();
    chk("j_addr_c1", mem_addr_o, 32'hc);
    step();
    step();
    step();
    chk("j_addr_c4", mem_addr_o, 32'hf);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h100;
    step();
    jump_flag_i = 1'b0;
    chk("j100_pc", pc_o, 32'h100);
    chk("j100_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("j100_addr", mem_addr_o, 32'h100);
    wait_valid("j100", 5, 32'h100, 32'h00341237);

    // Redirect coincident with consumption
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h20;
    step();
    jump_flag_i = 1'b0;
    chk("j20_pc", pc_o, 32'h20);
    chk("j20_addr", mem_addr_o, 32'h20);
    wait_valid("j20", 5, 32'h20, 32'heeffc0b7);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h40;
    step();
    jump_flag_i = 1'b0;
    chk("j40_pc", pc_o, 32'h40);
    chk("j40_valid", {31'd0, inst_valid_o}, 32'd0);
    wait_valid("j40", 5, 32'h40, 32'h12345678);

    // Redirect under stall to an unaligned address that wraps
    stall_i     = 1'b1;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hffff_fffe;
    step();
    jump_flag_i = 1'b0;
    chk("wrap_pc", pc_o, 32'hffff_fffe);
    chk("wrap_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("wrap_addr0", mem_addr_o, 32'hffff_fffe);
    step();
    chk("wrap_addr1", mem_addr_o, 32'hffff_ffff);
    step();
    chk("wrap_addr2", mem_addr_o, 32'h0);
    step();
    chk("wrap_addr3", mem_addr_o, 32'h1);
    wait_valid("wrap", 2, 32'hffff_fffe, 32'h05132211);
    stall_i = 1'b0;
    step();
    chk("wrap_next_pc", pc_o, 32'h2);
    chk("wrap_next_addr", mem_addr_o, 32'h2);

    // Reset in the middle of a fetch
    step();
    rst = 1'b0;
    #1;
    chk("mrst_pc", pc_o, 32'h0);
    chk("mrst_inst", inst_o, 32'h0);
    chk("mrst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("mrst_req", {31'd0, mem_req_o}, 32'd0);
    chk("mrst_stallreq", {31'd0, stallreq_o}, 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("rf0_req", {31'd0, mem_req_o}, 32'd1);
    chk("rf0_addr", mem_addr_o, 32'h0);
    wait_valid("rf0", 5, 32'h0, 32'h00a00513);

`ifdef ICACHE_EN
    // Refetch of 0 hits; after reset it misses again
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0;
    step();
    jump_flag_i = 1'b0;
    chk("hit_req", {31'd0, mem_req_o}, 32'd0);
    chk("hit_stallreq", {31'd0, stallreq_o}, 32'd0);
    chk("hit_valid_c1", {31'd0, inst_valid_o}, 32'd0);
    step();
    chk("hit_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("hit_inst", inst_o, 32'h00a00513);
    chk("hit_pc", pc_o, 32'h0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("miss_after_rst_req", {31'd0, mem_req_o}, 32'd1);
    wait_valid("miss_after_rst", 5, 32'h0, 32'h00a00513);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline, sitting directly upstream of the if_id register and the decode stage.
- Owns the PC and fetches each 32-bit instruction as four bytes over the shared 8-bit memory port, through the memory arbiter.
- Presents {pc, inst} with a valid flag and holds it while the pipeline stalls.
- Redirects immediately on a taken jump or branch signalled by decode, discarding any partial fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- ICACHE_LINES, 64, number of direct-mapped I-cache entries; power of two; used only with ICACHE_EN.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall_i  in  1  from ctrl: downstream cannot accept the instruction this cycle.
- jump_flag_i  in  1  from decode: redirect to jump_addr_i this cycle.
- jump_addr_i  in  32  redirect target byte address.
- mem_req_o  out  1  byte read request to arbiter.
- mem_addr_o  out  32  byte address of request.
- mem_grant_i  in  1  arbiter accepted the request this cycle.
- mem_data_i  in  8  read byte, valid the cycle after its grant.
- pc_o  out  32  PC of presented instruction.
- inst_o  out  32  presented instruction.
- inst_valid_o  out  1  pc_o/inst_o valid.
- stallreq_o  out  1  to ctrl: fetch in progress, no instruction available.

Behaviour:
- Reset (rst=0, async):
  - pc_o=RESET_PC, inst_o=0, inst_valid_o=0, mem_req_o=0, mem_addr_o=0, stallreq_o=0.
  - Counters cleared; FSM=FETCH.
  - First request is issued on the first edge after release.
- FSM states: FETCH (bytes outstanding), VALID (instruction held).
- Counters: issue_cnt and recv_cnt, 0..4.
- FETCH:
  - mem_req_o=1 while issue_cnt<4; mem_addr_o=pc+issue_cnt (32-bit wrap).
  - On mem_grant_i, issue_cnt++.
  - A byte returns the cycle after each grant; recv_cnt++; byte k goes to inst[8k+7:8k] (little-endian).
  - Requests may overlap responses: byte k+1 is issued in the same cycle byte k returns.
  - When recv_cnt reaches 4: the next edge sets inst_valid_o=1 and moves to VALID.
  - stallreq_o=1 throughout FETCH.
- Latency: with grant held high, fetch start to inst_valid_o=1 is 5 cycles. A grant gap of N cycles adds N.
- VALID:
  - mem_req_o=0; stallreq_o=0; pc_o/inst_o stable.
  - Consumed on any edge with inst_valid_o=1 and stall_i=0. Then pc_o<=pc_o+4, inst_valid_o<=0, counters cleared, FETCH.
  - With stall_i=1, everything is held indefinitely.
- Redirect (jump_flag_i=1) has highest priority, in any state, regardless of stall_i:
  - Next edge: pc_o<=jump_addr_i, inst_valid_o<=0, counters cleared, FETCH.
  - A byte returning the cycle after the redirect belongs to the aborted fetch and is discarded (tracked by an in-flight flag).
  - jump_addr_i is used as-is; alignment is not checked.
- Simultaneous consume and redirect: redirect wins; the PC does not increment.
- Reset mid-fetch: abort immediately; no byte is captured afterwards.
- mem_grant_i while mem_req_o=0 is ignored.

Optional Feature:
- Macro: ICACHE_EN.
- Defined: direct-mapped I-cache, ICACHE_LINES one-word entries.
  - index=pc[log2(ICACHE_LINES)+1:2]; tag=remaining upper PC bits.
  - Reset clears all valid bits.
  - On entering FETCH, lookup is done in the same cycle. A hit (word-aligned pc only) sets inst_valid_o next edge with no memory request: 1-cycle latency, stallreq_o=0.
  - A miss runs the byte fetch, then writes the line on completion.
  - Unaligned pc always misses and is never filled.
  - A redirect during a miss aborts without filling.
- Undefined: no cache storage; every fetch uses the byte port.

Test Plan:
- Reset release, grant always 1, memory at 0 holds 13 05 a0 00 -> mem_addr_o 0,1,2,3 on consecutive cycles; inst_valid_o=1 on cycle 5 with inst_o=32'h00a00513, pc_o=0.
- Valid instruction with stall_i=1 for 3 cycles -> outputs frozen, mem_req_o=0; on stall_i=0 the next fetch starts at pc 4.
- Grant low on cycles 1-2 of a fetch at pc 8 -> mem_addr_o stays 8 during the gap; valid arrives 2 cycles late with the correct word.
- jump_flag_i=1, jump_addr_i=32'h100 after 2 bytes received -> the returning byte is dropped; fetch restarts at 0x100; inst_o comes from mem[0x100..0x103].
- jump_flag_i=1 together with consumption (stall_i=0) at pc 0x20, target 0x40 -> pc_o=0x40, never 0x24.
- ICACHE_EN: loop fetching 0x0 twice -> second fetch has no mem_req_o and valid 1 cycle after entering FETCH; asserting reset then refetching misses.
